// File: rtl/game_viewport_timing.sv
// VGA raster generator with a centred, integer-upscaled game viewport.
// Emits sync, game-space coordinates and strobes one clock after the counter state.
module game_viewport_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter bit SYNC_POS = 1'b1,
  parameter int GAME_W   = 224,
  parameter int GAME_H   = 288,
  parameter int SCALE    = 3
) (
  input  logic                      vga_pix_clk,
  input  logic                      rst,
  output logic                      hsync,
  output logic                      vsync,
  output logic [$clog2(GAME_W)-1:0] sx,
  output logic [$clog2(GAME_H)-1:0] sy,
  output logic                      game_pix_stb,
  output logic                      frame_stb,
  output logic                      display_enabled
);

  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_OFF  = (H_ACTIVE - GAME_W * SCALE) / 2;
  localparam int Y_OFF  = (V_ACTIVE - GAME_H * SCALE) / 2;
  localparam int X_END  = X_OFF + GAME_W * SCALE;
  localparam int Y_END  = Y_OFF + GAME_H * SCALE;
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;
  localparam int HW     = $clog2(H_TOT);
  localparam int VW     = $clog2(V_TOT);
  localparam int GXW    = $clog2(GAME_W);
  localparam int GYW    = $clog2(GAME_H);
  localparam int SW     = (SCALE > 1) ? $clog2(SCALE) : 1;

  logic [HW-1:0]  hc_q, hc_d;
  logic [VW-1:0]  vc_q, vc_d;
  logic [SW-1:0]  xs_q, xs_d, ys_q, ys_d;
  logic [GXW-1:0] gx_q, gx_d, sx_q;
  logic [GYW-1:0] gy_q, gy_d, sy_q;
  logic           hs_q, vs_q, stb_q, frm_q, de_q;
  logic           hc_wrap, vc_wrap, in_h, in_v, hs_act, vs_act;

  always_comb begin
    hc_wrap = (int'(hc_q) == H_TOT - 1);
    vc_wrap = (int'(vc_q) == V_TOT - 1);
    in_h    = (int'(hc_q) >= X_OFF) && (int'(hc_q) < X_END);
    in_v    = (int'(vc_q) >= Y_OFF) && (int'(vc_q) < Y_END);
    hs_act  = (int'(hc_q) >= HS_BEG) && (int'(hc_q) < HS_END);
    vs_act  = (int'(vc_q) >= VS_BEG) && (int'(vc_q) < VS_END);

    hc_d = hc_wrap ? '0 : hc_q + HW'(1);
    vc_d = vc_q;
    if (hc_wrap) vc_d = vc_wrap ? '0 : vc_q + VW'(1);

    // Sub-pixel counters are re-armed on the clock whose next state enters the
    // viewport, so gx/gy are already 0 on the first viewport column/line.
    xs_d = xs_q;
    gx_d = gx_q;
    if (int'(hc_d) == X_OFF) begin
      xs_d = '0;
      gx_d = '0;
    end else if (in_h) begin
      if (int'(xs_q) == SCALE - 1) begin
        xs_d = '0;
        gx_d = gx_q + GXW'(1);
      end else begin
        xs_d = xs_q + SW'(1);
      end
    end

    ys_d = ys_q;
    gy_d = gy_q;
    if (hc_wrap) begin
      if (int'(vc_d) == Y_OFF) begin
        ys_d = '0;
        gy_d = '0;
      end else if (in_v) begin
        if (int'(ys_q) == SCALE - 1) begin
          ys_d = '0;
          gy_d = gy_q + GYW'(1);
        end else begin
          ys_d = ys_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      hc_q  <= '0;
      vc_q  <= '0;
      xs_q  <= '0;
      ys_q  <= '0;
      gx_q  <= '0;
      gy_q  <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
      stb_q <= 1'b0;
      frm_q <= 1'b0;
      de_q  <= 1'b0;
      hs_q  <= !SYNC_POS;
      vs_q  <= !SYNC_POS;
    end else begin
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      xs_q  <= xs_d;
      ys_q  <= ys_d;
      gx_q  <= gx_d;
      gy_q  <= gy_d;
      sx_q  <= in_h ? gx_q : '0;
      sy_q  <= in_v ? gy_q : '0;
      de_q  <= in_h && in_v;
      stb_q <= in_h && in_v && (int'(xs_q) == 0);
      frm_q <= (int'(hc_q) == 0) && (int'(vc_q) == 0);
      hs_q  <= hs_act ? SYNC_POS : !SYNC_POS;
      vs_q  <= vs_act ? SYNC_POS : !SYNC_POS;
    end
  end

  assign hsync           = hs_q;
  assign vsync           = vs_q;
  assign sx              = sx_q;
  assign sy              = sy_q;
  assign game_pix_stb    = stb_q;
  assign frame_stb       = frm_q;
  assign display_enabled = de_q;

endmodule
